// File: rtl/storage_arbiter_ctrl_if.sv
// -----------------------------------------------------------------------------
// storage_arbiter_ctrl_if
// Handshake bundle between the two requesters and the storage arbiter.
//   req0_* / req1_* : valid, write (1 = write, 0 = read), wdata from each
//                     requester; ready back from the controller (1-cycle pulse).
//   rd_valid/rd_data/rd_owner : registered read result and the requester
//                     that issued the read.
// master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface storage_arbiter_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_write;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_write;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_owner;

  modport master (
    output req0_valid, req0_write, req0_wdata,
    output req1_valid, req1_write, req1_wdata,
    input  req0_ready, req1_ready,
    input  rd_valid, rd_data, rd_owner
  );

  modport slave (
    input  req0_valid, req0_write, req0_wdata,
    input  req1_valid, req1_write, req1_wdata,
    output req0_ready, req1_ready,
    output rd_valid, rd_data, rd_owner
  );
endinterface

// File: rtl/storage_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// storage_arbiter_ctrl
// Shares one storage engine (single holding register, FIFO or LIFO, selected
// by a loaded mode) between two requesters. A round-robin arbiter picks one
// request in IDLE; the operation is acknowledged with a one-cycle ready in
// EXEC and commits on the edge leaving EXEC (one operation per 2 cycles).
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_cfg_mode  : 01 BUFFER, 10 FIFO, 11 LIFO, 00 disabled
//   i_cfg_load  : latch i_cfg_mode and clear the storage (IDLE only)
//   bus         : requester handshake + read result (slave modport)
//   o_count     : current occupancy
//   o_full      : count == DEPTH (BUFFER: count == 1), combinational
//   o_empty     : count == 0, combinational
//   o_err       : one-cycle pulse on overflow / underflow
//   o_mode      : currently latched mode
// -----------------------------------------------------------------------------
module storage_arbiter_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            i_cfg_mode,
  input  logic                  i_cfg_load,
  storage_arbiter_ctrl_if.slave bus,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_err,
  output logic [1:0]            o_mode
);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_BUF  = 2'b01;
  localparam logic [1:0] MODE_FIFO = 2'b10;
  localparam logic [1:0] MODE_LIFO = 2'b11;

  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_last_grant;
  logic              r_op_write;
  logic [DATA_W-1:0] r_op_wdata;
  logic              r_op_id;
  logic              r_ready0;
  logic              r_ready1;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_owner;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_full;
  logic              w_empty;
  logic              w_any_valid;
  logic              w_grant_id;
  logic              w_grant_write;
  logic [DATA_W-1:0] w_grant_wdata;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_mem_rdata;
  logic              w_op_err;
  logic              w_op_rd;
  logic [ADDR_W:0]   w_count_nxt;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic              w_commit;

  // BUFFER mode holds at most one word, so "full" means one entry there.
  assign w_full  = (r_mode == MODE_BUF) ? (r_count == CNT_ONE) : (r_count == CNT_DEPTH);
  assign w_empty = (r_count == '0);

  // Round robin: a lone requester always wins, a tie goes to the one that
  // did not win last time.
  assign w_any_valid   = bus.req0_valid | bus.req1_valid;
  assign w_grant_id    = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
  assign w_grant_write = w_grant_id ? bus.req1_write : bus.req0_write;
  assign w_grant_wdata = w_grant_id ? bus.req1_wdata : bus.req0_wdata;

  // Decode of the latched operation; only used while in EXEC.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    w_mem_we     = 1'b0;
    w_wr_addr    = '0;
    w_rd_addr    = '0;
    w_op_err     = 1'b0;
    w_op_rd      = 1'b0;
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    case (r_mode)
      MODE_BUF: begin
        // Entry 0 is the holding register; reads are non-destructive.
        if (r_op_write) begin
          w_mem_we    = 1'b1;
          w_count_nxt = CNT_ONE;
        end else if (w_empty) begin
          w_op_err = 1'b1;
        end else begin
          w_op_rd = 1'b1;
        end
      end
      MODE_FIFO: begin
        if (r_op_write) begin
          if (w_full) begin
            w_op_err = 1'b1;
          end else begin
            w_mem_we     = 1'b1;
            w_wr_addr    = r_wr_ptr;
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;  // wraps naturally
            w_count_nxt  = r_count + CNT_ONE;
          end
        end else if (w_empty) begin
          w_op_err = 1'b1;
        end else begin
          w_op_rd      = 1'b1;
          w_rd_addr    = r_rd_ptr;
          w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
          w_count_nxt  = r_count - CNT_ONE;
        end
      end
      MODE_LIFO: begin
        // The stack pointer is the occupancy itself; top of stack is count-1.
        // At count == DEPTH the low bits are 0, so 0 - 1 wraps to DEPTH-1.
        if (r_op_write) begin
          if (w_full) begin
            w_op_err = 1'b1;
          end else begin
            w_mem_we    = 1'b1;
            w_wr_addr   = r_count[ADDR_W-1:0];
            w_count_nxt = r_count + CNT_ONE;
          end
        end else if (w_empty) begin
          w_op_err = 1'b1;
        end else begin
          w_op_rd     = 1'b1;
          w_rd_addr   = r_count[ADDR_W-1:0] - PTR_ONE;
          w_count_nxt = r_count - CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  assign w_mem_rdata = r_mem[w_rd_addr];
  assign w_commit    = (r_state == S_EXEC) && !reset;

  // NOTE: the storage array has no reset; its contents are don't-care after
  // reset and occupancy alone decides what is readable. Gating with reset
  // keeps an aborted EXEC write from landing.
  always_ff @(posedge clk) begin
    if (w_commit && w_mem_we) begin
      r_mem[w_wr_addr] <= r_op_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_OFF;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_last_grant <= 1'b1;
      r_op_write   <= 1'b0;
      r_op_wdata   <= '0;
      r_op_id      <= 1'b0;
      r_ready0     <= 1'b0;
      r_ready1     <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_owner   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cfg_load) begin
            r_mode   <= i_cfg_mode;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
          end else if ((r_mode != MODE_OFF) && w_any_valid) begin
            r_op_write   <= w_grant_write;
            r_op_wdata   <= w_grant_wdata;
            r_op_id      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_ready0     <= ~w_grant_id;
            r_ready1     <= w_grant_id;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_count  <= w_count_nxt;
          r_wr_ptr <= w_wr_ptr_nxt;
          r_rd_ptr <= w_rd_ptr_nxt;
          r_err    <= w_op_err;
          if (w_op_rd) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_mem_rdata;
            r_rd_owner <= r_op_id;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = r_ready0;
  assign bus.req1_ready = r_ready1;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = r_rd_data;
  assign bus.rd_owner   = r_rd_owner;
  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_err          = r_err;
  assign o_mode         = r_mode;

endmodule

// File: tb/tb_storage_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_storage_arbiter_ctrl
// Self-checking bench: reset checks, a table of directed operations, hand
// sequences for arbitration / reset-in-EXEC / load-vs-request, and a random
// run compared against a queue-based storage model.
// -----------------------------------------------------------------------------
module tb_storage_arbiter_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_BUF  = 2'b01;
  localparam logic [1:0] M_FIFO = 2'b10;
  localparam logic [1:0] M_LIFO = 2'b11;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      cfg_mode;
  logic            cfg_load;
  logic [ADDR_W:0] count;
  logic            full;
  logic            empty;
  logic            err;
  logic [1:0]      mode;

  storage_arbiter_ctrl_if #(.DATA_W(DATA_W)) bus ();

  storage_arbiter_ctrl #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_cfg_mode(cfg_mode),
    .i_cfg_load(cfg_load),
    .bus       (bus),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty),
    .o_err     (err),
    .o_mode    (mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit v, input bit wr, input logic [7:0] d);
    if (!id) begin
      bus.req0_valid = v; bus.req0_write = wr; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = wr; bus.req1_wdata = d;
    end
  endtask

  function automatic bit ready_of(input bit id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  task automatic do_reset;
    reset    = 1'b1;
    cfg_load = 1'b0;
    cfg_mode = M_OFF;
    set_req(0, 0, 0, 8'h00);
    set_req(1, 0, 0, 8'h00);
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] m);
    cfg_mode = m;
    cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
  endtask

  // One complete operation from a single requester. Returns what was seen in
  // the ready cycle and in the cycle after it (the result cycle).
  task automatic do_op(input bit id, input bit wr, input logic [7:0] d,
                       output bit rv_at_ready, output bit rv,
                       output logic [7:0] rd, output bit owner, output bit e);
    bit got;
    got = 1'b0;
    set_req(id, 1, wr, d);
    for (int i = 0; i < 16 && !got; i++) begin
      tick;
      got = ready_of(id);
    end
    check("grant_timeout", 32'(got), 32'd1);
    rv_at_ready = bus.rd_valid;
    set_req(id, 0, 0, 8'h00);
    tick;
    rv    = bus.rd_valid;
    rd    = bus.rd_data;
    owner = bus.rd_owner;
    e     = err;
  endtask

  typedef struct {
    bit         load;
    logic [1:0] mode;
    bit         id;
    bit         wr;
    logic [7:0] data;
    bit         exp_rv;
    logic [7:0] exp_rd;
    bit         exp_err;
    int         exp_count;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_load(input string tag, input logic [1:0] m);
    vec_t v;
    v = '{load: 1'b1, mode: m, id: 1'b0, wr: 1'b0, data: 8'h00, exp_rv: 1'b0,
          exp_rd: 8'h00, exp_err: 1'b0, exp_count: 0, tag: tag};
    return v;
  endfunction

  function automatic vec_t mk_w(input string tag, input bit id, input logic [7:0] d,
                                input bit e, input int cnt);
    vec_t v;
    v = '{load: 1'b0, mode: M_OFF, id: id, wr: 1'b1, data: d, exp_rv: 1'b0,
          exp_rd: 8'h00, exp_err: e, exp_count: cnt, tag: tag};
    return v;
  endfunction

  function automatic vec_t mk_r(input string tag, input bit id, input bit rv,
                                input logic [7:0] d, input bit e, input int cnt);
    vec_t v;
    v = '{load: 1'b0, mode: M_OFF, id: id, wr: 1'b0, data: 8'h00, exp_rv: rv,
          exp_rd: d, exp_err: e, exp_count: cnt, tag: tag};
    return v;
  endfunction

  task automatic run_table;
    vec_t       v;
    logic [1:0] cur_mode;
    bit         rv_r, rv, own, e;
    logic [7:0] rd;
    bit         exp_full;
    cur_mode = M_OFF;
    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.load) begin
        do_load(v.mode);
        cur_mode = v.mode;
        check({v.tag, "_mode"}, 32'(mode), 32'(v.mode));
      end else begin
        do_op(v.id, v.wr, v.data, rv_r, rv, rd, own, e);
        check({v.tag, "_rv_in_ready_cycle"}, 32'(rv_r), 32'd0);
        check({v.tag, "_rv"}, 32'(rv), 32'(v.exp_rv));
        if (v.exp_rv) begin
          check({v.tag, "_rdata"}, 32'(rd), 32'(v.exp_rd));
          check({v.tag, "_owner"}, 32'(own), 32'(v.id));
        end
        check({v.tag, "_err"}, 32'(e), 32'(v.exp_err));
        tick;
        check({v.tag, "_pulse_len"}, {30'd0, bus.rd_valid, err}, 32'd0);
      end
      exp_full = (cur_mode == M_BUF) ? (v.exp_count == 1) : (v.exp_count == DEPTH);
      check({v.tag, "_count"}, 32'(count), v.exp_count);
      check({v.tag, "_full"}, 32'(full), 32'(exp_full));
      check({v.tag, "_empty"}, 32'(empty), 32'(v.exp_count == 0));
    end
  endtask

  task automatic fill_table;
    vecs.delete();
    // FIFO: req0 writes, req1 reads back in order.
    vecs.push_back(mk_load("fifo_load", M_FIFO));
    vecs.push_back(mk_w("fifo_w_a1", 0, 8'hA1, 0, 1));
    vecs.push_back(mk_w("fifo_w_a2", 0, 8'hA2, 0, 2));
    vecs.push_back(mk_w("fifo_w_a3", 0, 8'hA3, 0, 3));
    vecs.push_back(mk_r("fifo_r_a1", 1, 1, 8'hA1, 0, 2));
    vecs.push_back(mk_r("fifo_r_a2", 1, 1, 8'hA2, 0, 1));
    vecs.push_back(mk_r("fifo_r_a3", 1, 1, 8'hA3, 0, 0));
    // LIFO: last in, first out.
    vecs.push_back(mk_load("lifo_load", M_LIFO));
    vecs.push_back(mk_w("lifo_w_11", 0, 8'h11, 0, 1));
    vecs.push_back(mk_w("lifo_w_22", 0, 8'h22, 0, 2));
    vecs.push_back(mk_w("lifo_w_33", 0, 8'h33, 0, 3));
    vecs.push_back(mk_r("lifo_r_33", 1, 1, 8'h33, 0, 2));
    vecs.push_back(mk_r("lifo_r_22", 1, 1, 8'h22, 0, 1));
    // BUFFER: overwrite, non-destructive reads, underflow after reload.
    vecs.push_back(mk_load("buf_load", M_BUF));
    vecs.push_back(mk_w("buf_w_5c", 0, 8'h5C, 0, 1));
    vecs.push_back(mk_w("buf_w_7e", 1, 8'h7E, 0, 1));
    vecs.push_back(mk_r("buf_r1", 0, 1, 8'h7E, 0, 1));
    vecs.push_back(mk_r("buf_r2", 1, 1, 8'h7E, 0, 1));
    vecs.push_back(mk_load("buf_reload", M_BUF));
    vecs.push_back(mk_r("buf_r_empty", 0, 0, 8'h00, 1, 0));
    // FIFO boundaries with pointers offset by 3 so both pointers wrap.
    vecs.push_back(mk_load("fifo2_load", M_FIFO));
    for (int i = 0; i < 3; i++) vecs.push_back(mk_w("fifo2_pre_w", 0, 8'(8'h01 + i), 0, i + 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk_r("fifo2_pre_r", 1, 1, 8'(8'h01 + i), 0, 2 - i));
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back(mk_w("fifo2_fill", 1'(i), 8'(8'hB0 + i), 0, i + 1));
    vecs.push_back(mk_w("fifo2_overflow", 0, 8'hEE, 1, DEPTH));
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back(mk_r("fifo2_drain", 1'(i), 1, 8'(8'hB0 + i), 0, DEPTH - 1 - i));
    vecs.push_back(mk_r("fifo2_underflow", 1, 0, 8'h00, 1, 0));
  endtask

  task automatic arb_test;
    int         n0, n1;
    int         grants[$];
    int         code;
    bit         rv_r, rv, own, e;
    logic [7:0] rd;
    logic [7:0] exp_order [6];
    exp_order = '{8'h40, 8'h80, 8'h41, 8'h81, 8'h42, 8'h82};
    do_reset;
    do_load(M_FIFO);
    n0 = 0;
    n1 = 0;
    set_req(0, 1, 1, 8'h40);
    set_req(1, 1, 1, 8'h80);
    for (int t = 1; t <= 20 && (n0 < 3 || n1 < 3); t++) begin
      tick;
      if (bus.req0_ready || bus.req1_ready) begin
        code = (bus.req0_ready && bus.req1_ready) ? 2 : (bus.req1_ready ? 1 : 0);
        grants.push_back(t * 4 + code);
      end
      if (bus.req0_ready) begin
        n0++;
        if (n0 == 3) set_req(0, 0, 0, 8'h00);
        else bus.req0_wdata = 8'(8'h40 + n0);
      end
      if (bus.req1_ready) begin
        n1++;
        if (n1 == 3) set_req(1, 0, 0, 8'h00);
        else bus.req1_wdata = 8'(8'h80 + n1);
      end
    end
    check("arb_grant_count", 32'(grants.size()), 32'd6);
    for (int k = 0; k < 6 && k < grants.size(); k++)
      check($sformatf("arb_grant_%0d", k), 32'(grants[k]), 32'((2 * k + 1) * 4 + (k % 2)));
    tick;
    check("arb_count", 32'(count), 32'd6);
    for (int k = 0; k < 6; k++) begin
      do_op(0, 0, 8'h00, rv_r, rv, rd, own, e);
      check($sformatf("arb_read_%0d", k), 32'(rd), 32'(exp_order[k]));
    end
  endtask

  task automatic reset_and_load_test;
    bit         rv_r, rv, own, e;
    logic [7:0] rd;
    // Reset arriving while a write is in EXEC cancels it.
    do_load(M_FIFO);
    set_req(0, 1, 1, 8'h77);
    tick;
    check("rst_exec_ready", 32'(bus.req0_ready), 32'd1);
    reset = 1'b1;
    set_req(0, 0, 0, 8'h00);
    tick;
    reset = 1'b0;
    check("rst_exec_count", 32'(count), 32'd0);
    check("rst_exec_mode", 32'(mode), 32'(M_OFF));
    // Mode 00: a pending request is never granted.
    set_req(0, 1, 1, 8'h55);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("mode_off_no_ready", {30'd0, bus.req0_ready, err}, 32'd0);
    end
    set_req(0, 0, 0, 8'h00);
    do_load(M_FIFO);
    do_op(0, 0, 8'h00, rv_r, rv, rd, own, e);
    check("rst_exec_nowrite_err", 32'(e), 32'd1);
    check("rst_exec_nowrite_rv", 32'(rv), 32'd0);
    // cfg_load beats a request in the same IDLE cycle; grant follows.
    cfg_mode = M_LIFO;
    cfg_load = 1'b1;
    set_req(0, 1, 1, 8'h99);
    tick;
    cfg_load = 1'b0;
    check("load_wins_no_ready", 32'(bus.req0_ready), 32'd0);
    check("load_wins_mode", 32'(mode), 32'(M_LIFO));
    tick;
    check("load_then_grant", 32'(bus.req0_ready), 32'd1);
    set_req(0, 0, 0, 8'h00);
    tick;
    check("load_then_count", 32'(count), 32'd1);
    do_op(1, 0, 8'h00, rv_r, rv, rd, own, e);
    check("load_then_read", 32'(rd), 32'h99);
  endtask

  // Reference model: storage contents as a queue, behaviour from the mode rules.
  task automatic random_test;
    logic [1:0] m;
    logic [7:0] q[$];
    bit         id, wr, exp_rv, exp_err;
    logic [7:0] d, exp_d;
    bit         rv_r, rv, own, e;
    logic [7:0] rd;
    m = M_FIFO;
    do_load(m);
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        m = 2'($urandom_range(1, 3));
        do_load(m);
        q.delete();
        check("rnd_load_count", 32'(count), 32'd0);
      end else begin
        id = 1'($urandom_range(0, 1));
        wr = ($urandom_range(0, 99) < (((n / 30) % 2 == 1) ? 75 : 30));
        d  = 8'($urandom);
        exp_rv  = 1'b0;
        exp_err = 1'b0;
        exp_d   = 8'h00;
        if (wr) begin
          if (m == M_BUF) begin
            q.delete();
            q.push_back(d);
          end else if (q.size() == DEPTH) exp_err = 1'b1;
          else q.push_back(d);
        end else if (q.size() == 0) begin
          exp_err = 1'b1;
        end else begin
          exp_rv = 1'b1;
          if (m == M_FIFO)      exp_d = q.pop_front();
          else if (m == M_LIFO) exp_d = q.pop_back();
          else                  exp_d = q[0];
        end
        do_op(id, wr, d, rv_r, rv, rd, own, e);
        check("rnd_rv", 32'(rv), 32'(exp_rv));
        if (exp_rv) begin
          check("rnd_rdata", 32'(rd), 32'(exp_d));
          check("rnd_owner", 32'(own), 32'(id));
        end
        check("rnd_err", 32'(e), 32'(exp_err));
        check("rnd_count", 32'(count), 32'(q.size()));
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    cfg_load = 1'b0;
    cfg_mode = M_OFF;
    set_req(0, 0, 0, 8'h00);
    set_req(1, 0, 0, 8'h00);
    fill_table;
    do_reset;
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_rd_owner", 32'(bus.rd_owner), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_mode", 32'(mode), 32'(M_OFF));
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    run_table;
    arb_test;
    reset_and_load_test;
    random_test;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/storage_arbiter_ctrl.md
Name: storage_arbiter_ctrl

Overview:
- Shares one storage engine between two requesters. The engine is a register buffer, a FIFO or a LIFO, chosen by a loaded mode.
- Owns the memory array, the pointers and occupancy, a round-robin arbiter and a two-state sequencer.
- Sits between the requester blocks and the storage datapath. It replaces free-running opcode decode with handshaked, one-at-a-time operations.

Parameters:
- DATA_W, 8, data width of stored words
- DEPTH, 8, number of storage entries; must be a power of 2, at least 2
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cfg_mode  input  2  01 = BUFFER, 10 = FIFO, 11 = LIFO, 00 = disabled
- cfg_load  input  1  latch cfg_mode and clear the storage
- req0_valid  input  1  requester 0 has an operation pending
- req0_write  input  1  1 = write, 0 = read (requester 0)
- req0_wdata  input  DATA_W  write data (requester 0)
- req0_ready  output  1  one-cycle grant/accept pulse to requester 0
- req1_valid, req1_write, req1_wdata, req1_ready: same as requester 0, for requester 1
- rd_valid  output  1  read data valid, one-cycle pulse
- rd_data  output  DATA_W  read result
- rd_owner  output  1  requester that issued the read
- count  output  ADDR_W+1  current occupancy
- full  output  1  count == DEPTH (BUFFER mode: count == 1)
- empty  output  1  count == 0
- err  output  1  one-cycle pulse on overflow or underflow
- mode  output  2  currently latched mode

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - mode = 00, count = 0, pointers = 0, all memory contents don't-care.
  - req*_ready = 0, rd_valid = 0, rd_data = 0, rd_owner = 0, err = 0.
  - last_grant = 1, so requester 0 wins the first arbitration.
  - Reset has priority over everything and aborts an operation in EXEC; that operation has no effect.
- FSM states: IDLE and EXEC.
- IDLE:
  - If cfg_load = 1: mode <= cfg_mode, count/pointers <= 0, stay in IDLE. Requests are ignored that cycle.
  - Else if mode != 00 and any req*_valid: pick the winner, latch its write bit, wdata and id, then go to EXEC.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: winner = !last_grant.
  - last_grant is updated to the winner on entry to EXEC.
- EXEC:
  - The winner's req*_ready = 1 for exactly this cycle. The requester must drop or replace its request at the end of this cycle.
  - The storage operation commits on the edge that leaves EXEC; the FSM always returns to IDLE.
  - cfg_load is ignored while in EXEC.
- Timing: throughput is one operation per 2 cycles. For a read, rd_valid/rd_data/rd_owner are registered and valid in the cycle after EXEC, for exactly 1 cycle.
- BUFFER (01):
  - Single holding register.
  - Write overwrites it and sets count = 1; no error when already full.
  - Read returns the value non-destructively; count is unchanged.
  - Read with count = 0: err pulse, no rd_valid.
- FIFO (10):
  - Write: mem[wr_ptr] <= wdata, wr_ptr++, count++.
  - Read: rd_data <= mem[rd_ptr], rd_ptr++, count--.
  - Both pointers wrap from DEPTH-1 to 0 (natural ADDR_W overflow).
- LIFO (11):
  - Write: mem[sp] <= wdata, sp++.
  - Read: rd_data <= mem[sp-1], sp--.
  - count == sp; no wrap.
- Boundary conditions (FIFO/LIFO):
  - Write when full: data dropped, pointers/count unchanged, err pulses in the cycle after EXEC, ready still pulses.
  - Read when empty: err pulses, rd_valid stays 0, ready still pulses.
- Mode 00: no grants; requests wait indefinitely.
- Flags: full and empty are combinational from count.

Test Plan:
- Reset, then load FIFO, then req0 writes 0xA1, 0xA2, 0xA3, then req1 issues 3 reads -> rd_data = A1, A2, A3 with rd_owner = 1; count returns to 0; each rd_valid comes 1 cycle after its ready.
- Load LIFO, write 0x11, 0x22, 0x33, then read twice -> rd_data = 33, 22; count = 1.
- Both requesters hold valid continuously with writes in FIFO mode -> grants alternate req0, req1, req0, ...; one ready pulse every 2 cycles; first grant goes to req0.
- FIFO: 8 writes (full = 1), 9th write -> err = 1 and the data is dropped; 8 reads return in order with wrap exercised; a 9th read gives err = 1 and no rd_valid.
- BUFFER: write 0x5C, write 0x7E, read twice -> 0x7E both times, count = 1; a read after a fresh load -> err pulse.
- Assert reset while in EXEC of a write -> count = 0 and no ready/err afterwards. A cfg_load asserted together with a valid request in IDLE -> the load wins and the request is granted on the next cycle.
